// File: rtl/mul_pkg.sv
// mul_pkg: shared encodings and sizing helpers for the multiply sequencer (cache build: MUL_RESULT_CACHE_EN)
package mul_pkg;
    localparam logic [1:0] FUNCT_MUL    = 2'b00;
    localparam logic [1:0] FUNCT_MULH   = 2'b01;
    localparam logic [1:0] FUNCT_MULHSU = 2'b10;
    localparam logic [1:0] FUNCT_MULHU  = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    function automatic int cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction
endpackage

// File: rtl/mul_result_cache.sv
// mul_result_cache: one-entry memo of the last completed multiply, used only when MUL_RESULT_CACHE_EN is defined
module mul_result_cache
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [1:0]      funct,
    output logic            hit,
    output logic [XLEN-1:0] hit_result,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_rs1,
    input  logic [XLEN-1:0] wr_rs2,
    input  logic [1:0]      wr_funct,
    input  logic [XLEN-1:0] wr_result
);
    logic            valid_q;
    logic [XLEN-1:0] rs1_q, rs2_q, result_q;
    logic [1:0]      funct_q;

    assign hit        = valid_q && rs1 == rs1_q && rs2 == rs2_q && funct == funct_q;
    assign hit_result = result_q;

    // Entry is overwritten by every completed calculation; only reset invalidates it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct_q  <= '0;
            result_q <= '0;
        end else if (wr_en) begin
            valid_q  <= 1'b1;
            rs1_q    <= wr_rs1;
            rs2_q    <= wr_rs2;
            funct_q  <= wr_funct;
            result_q <= wr_result;
        end
    end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: issues one op to a multicycle combinational multiplier and returns its result (optional MUL_RESULT_CACHE_EN)
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 2,
    parameter int TAGW    = 5
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            Req_Valid,
    output logic            Req_Ready,
    input  logic [XLEN-1:0] Rs1,
    input  logic [XLEN-1:0] Rs2,
    input  logic [1:0]      Funct_1_0,
    input  logic [TAGW-1:0] Rd_Tag,
    input  logic            Flush,
    output logic [XLEN-1:0] Mul_Multiplier,
    output logic [XLEN-1:0] Mul_Multiplicand,
    output logic [1:0]      Mul_Funct,
    output logic            Mul_En,
    input  logic [XLEN-1:0] Mul_Result,
    output logic            Rsp_Valid,
    input  logic            Rsp_Ready,
    output logic [XLEN-1:0] Rsp_Result,
    output logic [TAGW-1:0] Rsp_Tag,
    output logic            Busy
);
    localparam int CW = cnt_width(LATENCY);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rs1_q, rs2_q, result_q, hit_result;
    logic [1:0]      funct_q;
    logic [TAGW-1:0] tag_q;
    logic            accept, capture, hit;

`ifdef MUL_RESULT_CACHE_EN
    mul_result_cache #(.XLEN(XLEN)) u_cache (
        .clk       (CLK),
        .rst       (rst),
        .rs1       (Rs1),
        .rs2       (Rs2),
        .funct     (Funct_1_0),
        .hit       (hit),
        .hit_result(hit_result),
        .wr_en     (capture),
        .wr_rs1    (rs1_q),
        .wr_rs2    (rs2_q),
        .wr_funct  (funct_q),
        .wr_result (Mul_Result)
    );
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    assign Mul_Multiplier   = rs1_q;
    assign Mul_Multiplicand = rs2_q;
    assign Mul_Funct        = funct_q;
    assign Mul_En           = state == CALC;
    assign Rsp_Valid        = state == DONE;
    assign Rsp_Result       = result_q;
    assign Rsp_Tag          = tag_q;
    assign Busy             = state != IDLE;

    // Handshake and next state; Flush overrides everything and blocks acceptance
    always_comb begin
        Req_Ready = !Flush && (state == IDLE || (state == DONE && Rsp_Ready));
        accept    = Req_Valid && Req_Ready;
        capture   = state == CALC && cnt == '0 && !Flush;
        state_nxt = state;
        if (Flush)
            state_nxt = IDLE;
        else if (accept)
            state_nxt = hit ? DONE : CALC;
        else if (capture)
            state_nxt = DONE;
        else if (state == DONE && Rsp_Ready)
            state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand hold, latency countdown and result capture
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rs1_q    <= '0;
            rs2_q    <= '0;
            funct_q  <= '0;
            tag_q    <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                rs1_q   <= Rs1;
                rs2_q   <= Rs2;
                funct_q <= Funct_1_0;
                tag_q   <= Rd_Tag;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == CALC && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (capture)
                result_q <= Mul_Result;
            else if (accept && hit)
                result_q <= hit_result;
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed self-checking bench for mul_seq_ctrl with a behavioural multiplier attached
module tb_mul_seq_ctrl;
    import mul_pkg::*;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        Req_Valid = 1'b0, Req_Ready;
    logic [31:0] Rs1 = '0, Rs2 = '0;
    logic [1:0]  Funct_1_0 = '0;
    logic [4:0]  Rd_Tag = '0;
    logic        Flush = 1'b0;
    logic [31:0] Mul_Multiplier, Mul_Multiplicand, Mul_Result;
    logic [1:0]  Mul_Funct;
    logic        Mul_En, Rsp_Valid, Busy;
    logic        Rsp_Ready = 1'b0;
    logic [31:0] Rsp_Result;
    logic [4:0]  Rsp_Tag;

    int n_chk = 0;
    int n_fail = 0;
    int lat, en_cnt;

    always #5 CLK = ~CLK;

    mul_seq_ctrl #(.XLEN(32), .LATENCY(2), .TAGW(5)) dut (
        .CLK(CLK), .rst(rst), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Rs1(Rs1), .Rs2(Rs2), .Funct_1_0(Funct_1_0), .Rd_Tag(Rd_Tag), .Flush(Flush),
        .Mul_Multiplier(Mul_Multiplier), .Mul_Multiplicand(Mul_Multiplicand),
        .Mul_Funct(Mul_Funct), .Mul_En(Mul_En), .Mul_Result(Mul_Result),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Result(Rsp_Result),
        .Rsp_Tag(Rsp_Tag), .Busy(Busy)
    );

    function automatic logic [31:0] mul_model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub;
        sa = {{32{a[31]}}, a};
        ua = {32'b0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (f)
            FUNCT_MUL:    mul_model = 32'((ua * ub) & 64'hFFFF_FFFF);
            FUNCT_MULH:   mul_model = 32'((sa * sb) >> 32);
            FUNCT_MULHSU: mul_model = 32'((sa * ub) >> 32);
            default:      mul_model = 32'((ua * ub) >> 32);
        endcase
    endfunction

    assign Mul_Result = Mul_En ? mul_model(Mul_Funct, Mul_Multiplier, Mul_Multiplicand) : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        Req_Valid = 1'b1;
        Funct_1_0 = f;
        Rs1 = a;
        Rs2 = b;
        Rd_Tag = t;
    endtask

    // Called right after the accepting edge; lat counts cycles from the request cycle to Rsp_Valid
    task automatic wait_rsp();
        lat = 1;
        en_cnt = 0;
        while (!Rsp_Valid && lat < 20) begin
            if (Mul_En) en_cnt++;
            step();
            lat++;
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        step();
        step();
        chk("rst_busy", Busy, 0);
        chk("rst_rsp_valid", Rsp_Valid, 0);
        chk("rst_mul_en", Mul_En, 0);
        chk("rst_req_ready", Req_Ready, 1);
        chk("rst_result", Rsp_Result, 0);
        chk("rst_tag", Rsp_Tag, 0);
        chk("rst_multiplier", Mul_Multiplier, 0);
        rst = 1'b0;
        step();

        // MUL 7 x 6
        Rsp_Ready = 1'b1;
        present(FUNCT_MUL, 32'd7, 32'd6, 5'd3);
        chk("mul_req_ready", Req_Ready, 1);
        step();
        Req_Valid = 1'b0;
        Rs1 = 32'hDEAD_BEEF;
        Rs2 = 32'h1234_5678;
        #1;
        chk("mul_hold_rs1", Mul_Multiplier, 32'd7);
        chk("mul_hold_rs2", Mul_Multiplicand, 32'd6);
        wait_rsp();
        chk("mul_latency", lat, 3);
        chk("mul_en_cycles", en_cnt, 2);
        chk("mul_result", Rsp_Result, 32'h0000_002A);
        chk("mul_tag", Rsp_Tag, 3);
        step();
        chk("mul_idle_after", Busy, 0);

        // MULHU with stalled consumer
        Rsp_Ready = 1'b0;
        present(FUNCT_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
        step();
        Req_Valid = 1'b0;
        chk("mulhu_req_ready_calc", Req_Ready, 0);
        wait_rsp();
        chk("mulhu_latency", lat, 3);
        chk("mulhu_result", Rsp_Result, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mulhu_hold_valid", Rsp_Valid, 1);
            chk("mulhu_hold_result", Rsp_Result, 32'hFFFF_FFFE);
            chk("mulhu_hold_tag", Rsp_Tag, 9);
            chk("mulhu_req_ready", Req_Ready, 0);
        end
        Rsp_Ready = 1'b1;
        step();
        chk("mulhu_taken", Rsp_Valid, 0);

        // Back-to-back MULH
        present(FUNCT_MULH, 32'hFFFF_FFFE, 32'd3, 5'd1);
        step();
        present(FUNCT_MULH, 32'h4000_0000, 32'd4, 5'd2);
        wait_rsp();
        chk("b2b_a_result", Rsp_Result, 32'hFFFF_FFFF);
        chk("b2b_a_tag", Rsp_Tag, 1);
        chk("b2b_req_ready_done", Req_Ready, 1);
        step();
        Req_Valid = 1'b0;
        chk("b2b_no_bubble_en", Mul_En, 1);
        chk("b2b_b_operand", Mul_Multiplier, 32'h4000_0000);
        wait_rsp();
        chk("b2b_b_latency", lat, 3);
        chk("b2b_b_result", Rsp_Result, 32'h0000_0001);
        chk("b2b_b_tag", Rsp_Tag, 2);
        step();

        // Flush in the second CALC cycle
        present(FUNCT_MUL, 32'd5, 32'd5, 5'd4);
        step();
        Req_Valid = 1'b0;
        step();
        chk("flush_in_calc", Mul_En, 1);
        Flush = 1'b1;
        #1;
        chk("flush_req_ready", Req_Ready, 0);
        step();
        Flush = 1'b0;
        chk("flush_idle", Busy, 0);
        chk("flush_rsp_valid", Rsp_Valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_rsp", Rsp_Valid, 0);
        end
        present(FUNCT_MUL, 32'd9, 32'd9, 5'd5);
        step();
        Req_Valid = 1'b0;
        wait_rsp();
        chk("post_flush_latency", lat, 3);
        chk("post_flush_result", Rsp_Result, 32'h0000_0051);
        chk("post_flush_tag", Rsp_Tag, 5);
        step();

        // Asynchronous reset while holding a response
        Rsp_Ready = 1'b0;
        present(FUNCT_MUL, 32'd3, 32'd4, 5'd7);
        step();
        Req_Valid = 1'b0;
        wait_rsp();
        chk("arst_pre_valid", Rsp_Valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_rsp_valid", Rsp_Valid, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_result", Rsp_Result, 0);
        chk("arst_tag", Rsp_Tag, 0);
        chk("arst_multiplier", Mul_Multiplier, 0);
        step();
        rst = 1'b0;
        step();

        // Repeated MULHSU: served from the cache only when it is built in
        Rsp_Ready = 1'b1;
        present(FUNCT_MULHSU, 32'h8000_0000, 32'd2, 5'd6);
        step();
        Req_Valid = 1'b0;
        wait_rsp();
        chk("hsu1_latency", lat, 3);
        chk("hsu1_result", Rsp_Result, 32'hFFFF_FFFF);
        step();
        present(FUNCT_MULHSU, 32'h8000_0000, 32'd2, 5'd8);
        step();
        Req_Valid = 1'b0;
        wait_rsp();
`ifdef MUL_RESULT_CACHE_EN
        chk("hsu2_latency", lat, 1);
        chk("hsu2_en_cycles", en_cnt, 0);
        chk("hsu2_mul_en", Mul_En, 0);
`else
        chk("hsu2_latency", lat, 3);
        chk("hsu2_en_cycles", en_cnt, 2);
`endif
        chk("hsu2_result", Rsp_Result, 32'hFFFF_FFFF);
        chk("hsu2_tag", Rsp_Tag, 8);
        step();
        chk("hsu2_idle", Busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
